// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int DEF_BITS      = 16;
    localparam int DEF_ADDR_BITS = 12;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; a lock restricts the pick to the owner.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       locked,
    input  logic       owner,
    output logic [1:0] grant
);

    logic [1:0] elig;

    always_comb begin
        elig = req;
        if (locked) begin
            elig = owner ? (req & 2'b10) : (req & 2'b01);
        end
        grant = 2'b00;
        case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Tie goes to the port that was not served last.
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port memory: grant, access, done.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int Bits     = DEF_BITS,
    parameter int AddrBits = DEF_ADDR_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0,
    input  logic                req1,
    input  logic                we0,
    input  logic                we1,
    input  logic                lock0,
    input  logic                lock1,
    input  logic [AddrBits-1:0] addr0,
    input  logic [AddrBits-1:0] addr1,
    input  logic [Bits-1:0]     wdata0,
    input  logic [Bits-1:0]     wdata1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                done0,
    output logic                done1,
    output logic [Bits-1:0]     rdata,
    output logic [AddrBits-1:0] mem_address,
    output logic [Bits-1:0]     mem_data_in,
    output logic                mem_read,
    output logic                mem_write,
    input  logic [Bits-1:0]     mem_data_out,
    output logic [1:0]          dbg_state
);

    // Handshake: reqN is held (with we/lock/addr/wdata stable) until gntN pulses;
    // the request fields are captured on the gnt cycle and reqN may then drop.
    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic                locked_q, locked_d;
    logic                we_q, we_d;
    logic [AddrBits-1:0] addr_q, addr_d;
    logic [Bits-1:0]     wdata_q, wdata_d;
    logic [Bits-1:0]     rdata_q, rdata_d;
    logic [1:0]          grant;

    rr_arb2 u_rr_arb2 (
        .req    ({req1, req0}),
        .last   (last_q),
        .locked (locked_q),
        .owner  (owner_q),
        .grant  (grant)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        locked_d    = locked_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        done0       = 1'b0;
        done1       = 1'b0;
        mem_address = '0;
        mem_data_in = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant != 2'b00) begin
                    gnt0     = grant[0] & rst_n;
                    gnt1     = grant[1] & rst_n;
                    owner_d  = grant[1];
                    we_d     = grant[1] ? we1 : we0;
                    addr_d   = grant[1] ? addr1 : addr0;
                    wdata_d  = grant[1] ? wdata1 : wdata0;
                    locked_d = grant[1] ? lock1 : lock0;
                    state_d  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_address = addr_q;
                mem_data_in = wdata_q;
                mem_read    = ~we_q;
                // A reset landing in this cycle must not corrupt memory.
                mem_write   = we_q & rst_n;
                if (!we_q) begin
                    rdata_d = mem_data_out;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done0   = ~owner_q & rst_n;
                done1   = owner_q & rst_n;
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            owner_q  <= PORT_CPU;
            last_q   <= PORT_DMA;
            locked_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            locked_q <= locked_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int B = 16;
    localparam int A = 12;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0, req1, we0, we1, lock0, lock1;
    logic [A-1:0] addr0, addr1;
    logic [B-1:0] wdata0, wdata1;
    logic         gnt0, gnt1, done0, done1;
    logic [B-1:0] rdata;
    logic [A-1:0] mem_address;
    logic [B-1:0] mem_data_in;
    logic         mem_read, mem_write;
    logic [B-1:0] mem_data_out;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    mem_arbiter #(.Bits(B), .AddrBits(A)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_read(mem_read), .mem_write(mem_write), .mem_data_out(mem_data_out),
        .dbg_state(dbg_state)
    );

    // Memory environment: combinational read, write on posedge, preload port.
    logic [B-1:0] mem [0:4095];
    logic         load_en;
    logic [A-1:0] load_addr;
    logic [B-1:0] load_data;

    always @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (mem_write) mem[mem_address] <= mem_data_in;
    end
    assign mem_data_out = mem_read ? mem[mem_address] : 16'hA5A5;

    typedef struct packed {
        logic         we;
        logic         lock;
        logic [A-1:0] addr;
        logic [B-1:0] wdata;
    } txn_t;

    txn_t         pq0[$];
    txn_t         pq1[$];
    int           gap0, gap1, gap_max;
    int           glog[$];
    int           wcount;
    int           checks, failures;

    // Reference model: phase 0 idle, 1 access, 2 done.
    int           m_phase;
    logic         m_port, m_last, m_locked, m_owner;
    txn_t         m_t;
    logic [B-1:0] m_rdata;
    logic [B-1:0] ref_mem [0:4095];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int p, input logic we, input logic lock,
                        input logic [A-1:0] a, input logic [B-1:0] d);
        txn_t t;
        t.we = we; t.lock = lock; t.addr = a; t.wdata = d;
        if (p == 0) pq0.push_back(t);
        else pq1.push_back(t);
    endtask

    task automatic step(input logic rst_val);
        txn_t t0, t1;
        logic c0, c1, e0, e1;
        @(negedge clk);
        rst_n = rst_val;
        if (gap0 > 0) gap0--;
        if (gap1 > 0) gap1--;
        req0 = (pq0.size() > 0) && (gap0 == 0);
        req1 = (pq1.size() > 0) && (gap1 == 0);
        t0 = req0 ? pq0[0] : '0;
        t1 = req1 ? pq1[0] : '0;
        we0 = t0.we; lock0 = t0.lock; addr0 = t0.addr; wdata0 = t0.wdata;
        we1 = t1.we; lock1 = t1.lock; addr1 = t1.addr; wdata1 = t1.wdata;
        #1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (mem_write) wcount++;
        case (m_phase)
            0: begin
                c0 = req0 && (!m_locked || m_owner == 1'b0);
                c1 = req1 && (!m_locked || m_owner == 1'b1);
                e0 = c0 && !(c1 && m_last == 1'b0) && rst_n;
                e1 = c1 && !(c0 && m_last == 1'b1) && rst_n;
                chk("idle_gnt0", gnt0, e0);
                chk("idle_gnt1", gnt1, e1);
                chk("idle_done", {done1, done0}, 0);
                chk("idle_memrw", {mem_write, mem_read}, 0);
                chk("idle_addr", mem_address, 0);
            end
            1: begin
                chk("acc_gnt", {gnt1, gnt0}, 0);
                chk("acc_done", {done1, done0}, 0);
                chk("acc_read", mem_read, !m_t.we);
                chk("acc_write", mem_write, m_t.we & rst_n);
                chk("acc_addr", mem_address, m_t.addr);
                chk("acc_wdata", mem_data_in, m_t.wdata);
            end
            default: begin
                chk("done_gnt", {gnt1, gnt0}, 0);
                chk("done0", done0, (m_port == 1'b0) & rst_n);
                chk("done1", done1, (m_port == 1'b1) & rst_n);
                chk("done_memrw", {mem_write, mem_read}, 0);
                chk("done_addr", mem_address, 0);
            end
        endcase
        chk("rdata", rdata, m_rdata);
        if (!rst_n) begin
            m_phase = 0; m_last = 1'b1; m_locked = 1'b0; m_owner = 1'b0; m_rdata = '0;
        end else begin
            case (m_phase)
                0: if (e0 || e1) begin
                    m_port   = e1;
                    m_t      = e1 ? t1 : t0;
                    m_owner  = e1;
                    m_locked = m_t.lock;
                    glog.push_back(e1 ? 1 : 0);
                    if (e1) begin
                        void'(pq1.pop_front());
                        gap1 = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
                    end else begin
                        void'(pq0.pop_front());
                        gap0 = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
                    end
                    m_phase = 1;
                end
                1: begin
                    if (!m_t.we) m_rdata = ref_mem[m_t.addr];
                    else ref_mem[m_t.addr] = m_t.wdata;
                    m_phase = 2;
                end
                default: begin
                    m_last  = m_port;
                    m_phase = 0;
                end
            endcase
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((pq0.size() > 0 || pq1.size() > 0 || m_phase != 0) && n < budget) begin
            step(1'b1);
            n++;
        end
        chk("drain_timeout", (n < budget), 1);
    endtask

    initial begin
        logic [B-1:0] pat;
        checks = 0; failures = 0; wcount = 0;
        gap0 = 0; gap1 = 0; gap_max = 0;
        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;

        // Preload memory while the DUT is held in reset.
        for (int a = 0; a < 256; a++) begin
            @(negedge clk);
            pat = (a == 5) ? 16'h200B : (a == 16) ? 16'h0777 : (16'(a) * 16'h0101) ^ 16'h5A3C;
            load_en = 1'b1; load_addr = 12'(a); load_data = pat;
            ref_mem[a] = pat;
        end
        @(negedge clk);
        load_en = 1'b0;
        m_phase = 0; m_last = 1'b1; m_locked = 1'b0; m_owner = 1'b0; m_rdata = '0;

        // Reset state and read after reset.
        step(1'b1);
        chk("reset_state", dbg_state, 0);
        push(0, 1'b0, 1'b0, 12'h005, 16'h0);
        drain(10);
        chk("t1_rdata", rdata, 16'h200B);

        // Port 1 write then read back.
        wcount = 0;
        push(1, 1'b1, 1'b0, 12'h0FF, 16'hBEEF);
        push(1, 1'b0, 1'b0, 12'h0FF, 16'h0);
        drain(20);
        chk("t2_wcount", wcount, 1);
        chk("t2_rdata", rdata, 16'hBEEF);

        // Simultaneous requests alternate.
        glog.delete();
        for (int i = 0; i < 2; i++) begin
            push(0, 1'b0, 1'b0, 12'(i + 1), 16'h0);
            push(1, 1'b0, 1'b0, 12'(i + 2), 16'h0);
        end
        drain(40);
        chk("t3_len", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) chk("t3_order", glog[i], i % 2);

        // Lock keeps port 0 as owner for its next transaction.
        glog.delete();
        push(0, 1'b0, 1'b1, 12'h00A, 16'h0);
        push(0, 1'b1, 1'b0, 12'h00A, 16'h4321);
        push(1, 1'b0, 1'b0, 12'h00A, 16'h0);
        drain(40);
        chk("t4_len", glog.size(), 3);
        if (glog.size() == 3) begin
            chk("t4_first", glog[0], 0);
            chk("t4_second", glog[1], 0);
            chk("t4_third", glog[2], 1);
        end
        chk("t4_rdata", rdata, 16'h4321);

        // Reset during the access cycle of a write.
        wcount = 0;
        push(0, 1'b1, 1'b0, 12'h010, 16'h1234);
        step(1'b1);
        step(1'b0);
        step(1'b1);
        chk("t5_state", dbg_state, 0);
        chk("t5_mem", mem[16], 16'h0777);
        chk("t5_wcount", wcount, 0);
        chk("t5_rdata", rdata, 16'h0000);

        // Idle quiet with held read data.
        push(0, 1'b0, 1'b0, 12'h0FF, 16'h0);
        drain(10);
        for (int i = 0; i < 10; i++) step(1'b1);
        chk("t6_rdata", rdata, 16'hBEEF);

        // Randomized traffic with gaps and occasional locks.
        gap_max = 3;
        for (int i = 0; i < 30; i++) begin
            push(0, 1'($urandom_range(0, 1)), (i != 29) && ($urandom_range(0, 3) == 0),
                 12'($urandom_range(0, 255)), 16'($urandom()));
            push(1, 1'($urandom_range(0, 1)), (i != 29) && ($urandom_range(0, 3) == 0),
                 12'($urandom_range(0, 255)), 16'($urandom()));
        end
        drain(5000);
        for (int i = 0; i < 5; i++) step(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port program/data memory (12-bit address, 16-bit word, combinational read, write on posedge clk).
- Port 0 is the CPU control unit (fetch/operand/store). Port 1 is the program loader / IO DMA port.
- Grants one requester at a time, drives the memory Read/Write strobes, registers read data and signals completion.
- Round-robin fairness, with a lock option for read-modify-write sequences.

Parameters:
- Bits, 16, data word width.
- AddrBits, 12, memory address width.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  synchronous active-low reset.
- req0 / req1  in  1  request from port 0 / port 1; held until gnt.
- we0 / we1  in  1  1 = write, 0 = read; sampled with gnt.
- lock0 / lock1  in  1  keep ownership after this transaction; sampled with gnt.
- addr0 / addr1  in  AddrBits  word address; sampled with gnt.
- wdata0 / wdata1  in  Bits  write data; sampled with gnt.
- gnt0 / gnt1  out  1  one-cycle accept pulse (combinational in S_IDLE).
- done0 / done1  out  1  one-cycle completion pulse.
- rdata  out  Bits  registered read data, valid while done is high and held until the next read completes.
- mem_address  out  AddrBits  to memory address.
- mem_data_in  out  Bits  to memory data_in.
- mem_read  out  1  to memory Read.
- mem_write  out  1  to memory Write.
- mem_data_out  in  Bits  from memory data_out.

Behaviour:
- States:
  - S_IDLE -> S_ACCESS when a request is granted.
  - S_ACCESS -> S_DONE unconditionally.
  - S_DONE -> S_IDLE unconditionally.
- Reset values: state S_IDLE; owner=0; last=1 (port 0 wins the first tie); locked=0; rdata=0. All gnt, done and mem_* outputs are 0.
- Arbitration in S_IDLE:
  - If locked=1, only the owner may be granted; the other port's request is ignored until the owner's next transaction completes with its lock=0.
  - Otherwise a single request wins.
  - Both requesting: the port != last wins.
- On grant, capture addr, we, wdata and lock into *_q registers; set owner=port and locked=lock_q.
- S_ACCESS:
  - mem_address=addr_q. mem_data_in=wdata_q.
  - mem_read = ~we_q. mem_write = we_q & rst_n, so a reset during ACCESS suppresses the write.
  - For a read, rdata <= mem_data_out at the closing edge.
- S_DONE:
  - done<owner>=1; mem_* outputs are 0.
  - last <= owner.
  - locked stays as captured; it clears only when a locked owner issues a transaction with lock=0.
- Latency: grant in cycle N, memory access in cycle N+1, done in cycle N+2. A new grant is possible at N+3, giving 1 transaction per 3 cycles.
- Outside S_ACCESS, mem_read=0 and mem_write=0. Memory data_out is then high-Z and is never sampled.
- A request that drops before gnt is simply not served; there is no error.
- Addresses pass through unmodified; range checking is the memory's concern.
- Reset mid-operation: the in-flight transaction is abandoned with no done pulse. A write is suppressed only if rst_n is low during S_ACCESS. locked is cleared.
- A port is never granted twice in one cycle. gnt0 & gnt1 never both assert; the same holds for done0 & done1.

Decomposition:
- Shared package mem_arb_pkg:
  - State enum: S_IDLE, S_ACCESS, S_DONE.
  - Port index constants: PORT_CPU=0, PORT_DMA=1.
  - Default widths.
- Sub-module rr_arb2: combinational 2-way round-robin pick with inputs req[1:0], last, locked, owner and output one-hot grant. Everything else stays in mem_arbiter.

Test Plan:
- Read after reset: req0=1, we0=0, addr0=12'h005, memory holds 16'h200B at 5. Expect gnt0 in cycle 0, mem_read=1 with mem_address=5 in cycle 1, done0=1 with rdata=16'h200B in cycle 2.
- Write then read back: port 1 writes 16'hBEEF to 12'h0FF, then reads 12'h0FF. Expect mem_write high for exactly one cycle, then rdata=16'hBEEF on done1.
- Simultaneous requests: req0 and req1 held high for 4 transactions. Expect the grant order 0,1,0,1 and no double done.
- Lock: port 0 reads 12'h00A with lock0=1 while req1 is held. Expect port 0's next write (lock0=0) granted before port 1, then port 1 granted.
- Reset mid-write: rst_n low during S_ACCESS of a write of 16'h1234 to 12'h010. Expect mem_write=0 that cycle, memory[0x010] unchanged, no done, and all outputs at reset values the next cycle.
- Idle quiet: no requests for 10 cycles. Expect mem_read, mem_write, gnt* and done* all 0, and rdata held at its last value.
